// File: rtl/conv_param_sched.sv
// conv_param_sched: streams weight and bias tiles from their read buffers to the convolution core.
// Optional macro CONV_PARAM_SCHED_PERF_EN adds the perf_stall_cycles backpressure counter.
module conv_param_sched #(
    parameter int WEIGHT_PRECISION_0 = 8,
    parameter int BIAS_PRECISION_0   = 8,
    parameter int IN_C               = 4,
    parameter int KERNEL_X           = 2,
    parameter int KERNEL_Y           = 2,
    parameter int OUT_C              = 4,
    parameter int UNROLL_KERNEL_OUT  = 4,
    parameter int UNROLL_OUT_C       = 4,
    parameter int SLIDING_NUM        = 8,
    localparam int K_TILES  = (KERNEL_X * KERNEL_Y * IN_C) / UNROLL_KERNEL_OUT,
    localparam int OC_TILES = OUT_C / UNROLL_OUT_C,
    localparam int WA       = ((K_TILES * OC_TILES) > 1) ? $clog2(K_TILES * OC_TILES) : 1,
    localparam int BA       = (OC_TILES > 1) ? $clog2(OC_TILES) : 1,
    localparam int WN       = UNROLL_KERNEL_OUT * UNROLL_OUT_C
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          w_rd_en,
    output logic [WA-1:0]                 w_rd_addr,
    input  logic [WEIGHT_PRECISION_0-1:0] w_rd_data [WN],
    output logic                          b_rd_en,
    output logic [BA-1:0]                 b_rd_addr,
    input  logic [BIAS_PRECISION_0-1:0]   b_rd_data [UNROLL_OUT_C],
    output logic [WEIGHT_PRECISION_0-1:0] weight [WN],
    output logic                          weight_valid,
    input  logic                          weight_ready,
    output logic [BIAS_PRECISION_0-1:0]   bias [UNROLL_OUT_C],
    output logic                          bias_valid,
    input  logic                          bias_ready
`ifdef CONV_PARAM_SCHED_PERF_EN
    ,
    output logic [31:0]                   perf_stall_cycles
`endif
);

    localparam int KW      = (K_TILES > 1) ? $clog2(K_TILES) : 1;
    localparam int OCW     = BA;
    localparam int SW      = (SLIDING_NUM > 1) ? $clog2(SLIDING_NUM) : 1;
    localparam int W_TOTAL = SLIDING_NUM * OC_TILES * K_TILES;
    localparam int B_TOTAL = SLIDING_NUM * OC_TILES;
    localparam int WCW     = $clog2(W_TOTAL + 1);
    localparam int BCW     = $clog2(B_TOTAL + 1);

    localparam logic [KW-1:0]  K_LAST     = KW'(K_TILES - 1);
    localparam logic [OCW-1:0] OC_LAST    = OCW'(OC_TILES - 1);
    localparam logic [SW-1:0]  S_LAST     = SW'(SLIDING_NUM - 1);
    localparam logic [WCW-1:0] W_HS_LAST  = WCW'(W_TOTAL - 1);
    localparam logic [BCW-1:0] B_HS_LAST  = BCW'(B_TOTAL - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_r, state_nxt_s;
    logic   accept_s, run_s;

    logic [KW-1:0]  wk_r;
    logic [OCW-1:0] woc_r;
    logic [SW-1:0]  ws_r;
    logic           w_iss_all_r, w_inflight_r, w_fin_r, w_pop_s, w_complete_s;
    logic [1:0]     w_occ_r;
    logic [2:0]     w_outstanding_s;
    logic [WCW-1:0] w_hs_cnt_r;
    logic [WEIGHT_PRECISION_0-1:0] w_buf0_r [WN];
    logic [WEIGHT_PRECISION_0-1:0] w_buf1_r [WN];

    logic [OCW-1:0] boc_r;
    logic [SW-1:0]  bs_r;
    logic           b_iss_all_r, b_inflight_r, b_fin_r, b_pop_s, b_complete_s;
    logic [1:0]     b_occ_r;
    logic [2:0]     b_outstanding_s;
    logic [BCW-1:0] b_hs_cnt_r;
    logic [BIAS_PRECISION_0-1:0] b_buf0_r [UNROLL_OUT_C];
    logic [BIAS_PRECISION_0-1:0] b_buf1_r [UNROLL_OUT_C];

    assign accept_s = (state_r == ST_IDLE) && start;
    assign run_s    = (state_r == ST_RUN);
    assign busy     = run_s;
    assign done     = (state_r == ST_DONE);

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame sequencing: RUN ends once both streams have delivered every tile
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (w_complete_s && b_complete_s) state_nxt_s = ST_DONE;
                else                              state_nxt_s = ST_RUN;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Outstanding = stored + in flight - leaving this cycle; a read only issues if it still fits
    assign w_pop_s         = weight_valid && weight_ready;
    assign w_outstanding_s = {1'b0, w_occ_r} + {2'b00, w_inflight_r} - {2'b00, w_pop_s};
    assign w_rd_en         = run_s && !w_iss_all_r && (w_outstanding_s < 3'd2);
    assign w_rd_addr       = WA'(int'(woc_r) * K_TILES + int'(wk_r));
    assign w_complete_s    = w_fin_r || (w_pop_s && (w_hs_cnt_r == W_HS_LAST));
    assign weight_valid    = (w_occ_r != 2'd0) || w_inflight_r;

    assign b_pop_s         = bias_valid && bias_ready;
    assign b_outstanding_s = {1'b0, b_occ_r} + {2'b00, b_inflight_r} - {2'b00, b_pop_s};
    assign b_rd_en         = run_s && !b_iss_all_r && (b_outstanding_s < 3'd2);
    assign b_rd_addr       = boc_r;
    assign b_complete_s    = b_fin_r || (b_pop_s && (b_hs_cnt_r == B_HS_LAST));
    assign bias_valid      = (b_occ_r != 2'd0) || b_inflight_r;

    // Output head: oldest stored tile, or read data straight through when nothing is stored
    always_comb begin
        for (int i = 0; i < WN; i++) begin
            if (w_occ_r != 2'd0) weight[i] = w_buf0_r[i];
            else                 weight[i] = w_rd_data[i];
        end
        for (int i = 0; i < UNROLL_OUT_C; i++) begin
            if (b_occ_r != 2'd0) bias[i] = b_buf0_r[i];
            else                 bias[i] = b_rd_data[i];
        end
    end

    // Weight read loop counters: k innermost, then oc, then sliding position
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            wk_r        <= {KW{1'b0}};
            woc_r       <= {OCW{1'b0}};
            ws_r        <= {SW{1'b0}};
            w_iss_all_r <= 1'b0;
        end else if (w_rd_en) begin
            if (wk_r == K_LAST) begin
                wk_r <= {KW{1'b0}};
                if (woc_r == OC_LAST) begin
                    woc_r <= {OCW{1'b0}};
                    if (ws_r == S_LAST) begin
                        ws_r        <= {SW{1'b0}};
                        w_iss_all_r <= 1'b1;
                    end else begin
                        ws_r <= ws_r + SW'(1);
                    end
                end else begin
                    woc_r <= woc_r + OCW'(1);
                end
            end else begin
                wk_r <= wk_r + KW'(1);
            end
        end
    end

    // Bias read loop counters: oc innermost, then sliding position
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            boc_r       <= {OCW{1'b0}};
            bs_r        <= {SW{1'b0}};
            b_iss_all_r <= 1'b0;
        end else if (b_rd_en) begin
            if (boc_r == OC_LAST) begin
                boc_r <= {OCW{1'b0}};
                if (bs_r == S_LAST) begin
                    bs_r        <= {SW{1'b0}};
                    b_iss_all_r <= 1'b1;
                end else begin
                    bs_r <= bs_r + SW'(1);
                end
            end else begin
                boc_r <= boc_r + OCW'(1);
            end
        end
    end

    // Handshake counters flag when each stream has delivered its final tile
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            w_hs_cnt_r <= {WCW{1'b0}};
            w_fin_r    <= 1'b0;
            b_hs_cnt_r <= {BCW{1'b0}};
            b_fin_r    <= 1'b0;
        end else begin
            if (w_pop_s) begin
                w_hs_cnt_r <= w_hs_cnt_r + WCW'(1);
                if (w_hs_cnt_r == W_HS_LAST) w_fin_r <= 1'b1;
            end
            if (b_pop_s) begin
                b_hs_cnt_r <= b_hs_cnt_r + BCW'(1);
                if (b_hs_cnt_r == B_HS_LAST) b_fin_r <= 1'b1;
            end
        end
    end

    // Weight 2-entry buffer; a return and a pop in the same cycle keep occupancy constant
    always_ff @(posedge clk) begin
        if (rst) begin
            w_occ_r      <= 2'd0;
            w_inflight_r <= 1'b0;
            w_buf0_r     <= '{default: '0};
            w_buf1_r     <= '{default: '0};
        end else begin
            w_inflight_r <= w_rd_en;
            case ({w_inflight_r, w_pop_s})
                2'b10: begin
                    if (w_occ_r == 2'd0) w_buf0_r <= w_rd_data;
                    else                 w_buf1_r <= w_rd_data;
                    w_occ_r <= w_occ_r + 2'd1;
                end
                2'b01: begin
                    w_buf0_r <= w_buf1_r;
                    w_occ_r  <= w_occ_r - 2'd1;
                end
                2'b11: begin
                    if (w_occ_r == 2'd1) begin
                        w_buf0_r <= w_rd_data;
                    end else if (w_occ_r == 2'd2) begin
                        w_buf0_r <= w_buf1_r;
                        w_buf1_r <= w_rd_data;
                    end
                end
                default: w_occ_r <= w_occ_r;
            endcase
        end
    end

    // Bias 2-entry buffer, same discipline as the weight side
    always_ff @(posedge clk) begin
        if (rst) begin
            b_occ_r      <= 2'd0;
            b_inflight_r <= 1'b0;
            b_buf0_r     <= '{default: '0};
            b_buf1_r     <= '{default: '0};
        end else begin
            b_inflight_r <= b_rd_en;
            case ({b_inflight_r, b_pop_s})
                2'b10: begin
                    if (b_occ_r == 2'd0) b_buf0_r <= b_rd_data;
                    else                 b_buf1_r <= b_rd_data;
                    b_occ_r <= b_occ_r + 2'd1;
                end
                2'b01: begin
                    b_buf0_r <= b_buf1_r;
                    b_occ_r  <= b_occ_r - 2'd1;
                end
                2'b11: begin
                    if (b_occ_r == 2'd1) begin
                        b_buf0_r <= b_rd_data;
                    end else if (b_occ_r == 2'd2) begin
                        b_buf0_r <= b_buf1_r;
                        b_buf1_r <= b_rd_data;
                    end
                end
                default: b_occ_r <= b_occ_r;
            endcase
        end
    end

`ifdef CONV_PARAM_SCHED_PERF_EN
    // Saturating count of RUN cycles in which either stream is held off by the consumer
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            perf_stall_cycles <= 32'd0;
        end else if (run_s && ((weight_valid && !weight_ready) || (bias_valid && !bias_ready))
                     && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_param_sched.sv
// Self-checking bench for conv_param_sched (default parameters, scoreboard of expected tiles).
module tb_conv_param_sched;
    localparam int WN    = 16;
    localparam int BN    = 4;
    localparam int WTOT  = 32;
    localparam int BTOT  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, busy, done;
    logic       w_rd_en, b_rd_en, weight_valid, weight_ready, bias_valid, bias_ready;
    logic [1:0] w_rd_addr;
    logic [0:0] b_rd_addr;
    logic [7:0] w_rd_data [WN];
    logic [7:0] b_rd_data [BN];
    logic [7:0] weight [WN];
    logic [7:0] bias [BN];
`ifdef CONV_PARAM_SCHED_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wq[$];
    int bq[$];
    int w_frame_hs, b_frame_hs, w_last, b_last, done_cnt, w_iss, w_hs_tot, w_max_out;

    conv_param_sched dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .weight(weight), .weight_valid(weight_valid), .weight_ready(weight_ready),
        .bias(bias), .bias_valid(bias_valid), .bias_ready(bias_ready)
`ifdef CONV_PARAM_SCHED_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    function automatic logic [7:0] wpat(input int a, input int i);
        return 8'((a * 37 + i * 5 + 17) & 255);
    endfunction

    function automatic logic [7:0] bpat(input int a, input int i);
        return 8'((a * 11 + i * 7 + 200) & 255);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer models: data one cycle after the read enable, junk otherwise
    always @(posedge clk) begin
        for (int i = 0; i < WN; i++) w_rd_data[i] <= w_rd_en ? wpat(int'(w_rd_addr), i) : 8'hEE;
        for (int i = 0; i < BN; i++) b_rd_data[i] <= b_rd_en ? bpat(int'(b_rd_addr), i) : 8'hEE;
    end

    task automatic wait_done(input string name, input int budget);
        int got = 0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin got = 1; break; end
            @(posedge clk); #1;
        end
        n_checks++;
        if (got !== 1) begin n_fail++; $display("FAIL %s_done_timeout: done=0 after %0d cycles, required 1", name, budget); end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; weight_ready = 1'b1; bias_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", done); end
        n_checks++; if (w_rd_en !== 1'b0 || b_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b%b required 00", w_rd_en, b_rd_en); end
        n_checks++; if (weight_valid !== 1'b0 || bias_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b%b required 00", weight_valid, bias_valid); end
`ifdef CONV_PARAM_SCHED_PERF_EN
        n_checks++; if (perf_stall_cycles !== 32'd0) begin n_fail++; $display("FAIL rst_perf: got %0d required 0", perf_stall_cycles); end
`endif
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_start_priority: busy=%b required 0", busy); end
    endtask

    task automatic test_basic();
        int t0, d0;
        d0 = done_cnt;
        pulse_start();
        t0 = cyc;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy); end
        n_checks++; if (w_rd_en !== 1'b1 || b_rd_en !== 1'b1) begin n_fail++; $display("FAIL basic_first_rd: got %b%b required 11", w_rd_en, b_rd_en); end
        n_checks++; if (w_rd_addr !== 2'd0 || b_rd_addr !== 1'b0) begin n_fail++; $display("FAIL basic_first_addr: got %0d/%0d required 0/0", w_rd_addr, b_rd_addr); end
        n_checks++; if (weight_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b required 0", weight_valid); end
        @(posedge clk); #1;
        n_checks++; if (weight_valid !== 1'b1 || bias_valid !== 1'b1) begin n_fail++; $display("FAIL basic_first_valid: got %b%b required 11", weight_valid, bias_valid); end
        wait_done("basic", 100);
        n_checks++; if (cyc - t0 !== 33) begin n_fail++; $display("FAIL basic_latency: done %0d cycles after first read, required 33", cyc - t0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done: got %b required 0", busy); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || done_cnt !== d0 + 1) begin n_fail++; $display("FAIL basic_done_pulse: done=%b count=%0d required 0/%0d", done, done_cnt, d0 + 1); end
    endtask

    task automatic test_w_backpressure();
        int got = 0;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (w_frame_hs >= 6) begin got = 1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (got !== 1) begin n_fail++; $display("FAIL bp_reach_tile6: got %0d tiles required 6", w_frame_hs); end
        weight_ready = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        n_checks++; if (w_rd_en !== 1'b0 || weight_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stalled: rd_en=%b valid=%b required 0/1", w_rd_en, weight_valid); end
        n_checks++; if (w_iss - w_hs_tot !== 2) begin n_fail++; $display("FAIL bp_outstanding: got %0d required 2", w_iss - w_hs_tot); end
        weight_ready = 1'b1;
        wait_done("bp", 200);
        n_checks++; if (w_max_out > 2) begin n_fail++; $display("FAIL bp_max_outstanding: got %0d required <=2", w_max_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_b_stall();
        int got = 0;
        bias_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            if (w_frame_hs >= WTOT) begin got = 1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (got !== 1) begin n_fail++; $display("FAIL bstall_weights: got %0d tiles required %0d", w_frame_hs, WTOT); end
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL bstall_busy: busy=%b done=%b required 1/0", busy, done); end
        n_checks++; if (bias_valid !== 1'b1 || b_frame_hs !== 0) begin n_fail++; $display("FAIL bstall_bias_held: valid=%b hs=%0d required 1/0", bias_valid, b_frame_hs); end
        bias_ready = 1'b1;
        wait_done("bstall", 50);
        n_checks++; if (b_frame_hs !== BTOT) begin n_fail++; $display("FAIL bstall_bias_count: got %0d required %0d", b_frame_hs, BTOT); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_during_run();
        int d0;
        d0 = done_cnt;
        pulse_start();
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin start = 1'b1; @(posedge clk); #1; end
        start = 1'b0;
        wait_done("restart", 100);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL restart_done_count: got %0d required %0d", done_cnt - d0, 1); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_queued: busy=%b required 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        int d0, got = 0;
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            if (w_frame_hs >= 20) begin got = 1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (got !== 1) begin n_fail++; $display("FAIL midrst_reach_tile20: got %0d required 20", w_frame_hs); end
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (weight_valid !== 1'b0 || bias_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b%b required 00", weight_valid, bias_valid); end
        n_checks++; if (busy !== 1'b0 || w_rd_en !== 1'b0 || b_rd_en !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_rd: got %b%b%b required 000", busy, w_rd_en, b_rd_en); end
        repeat (5) begin @(posedge clk); #1; end
        n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses required 0", done_cnt - d0); end
        pulse_start();
        wait_done("midrst_refill", 100);
        n_checks++; if (w_frame_hs !== WTOT) begin n_fail++; $display("FAIL midrst_refill_count: got %0d required %0d", w_frame_hs, WTOT); end
        @(posedge clk); #1;
    endtask

`ifdef CONV_PARAM_SCHED_PERF_EN
    task automatic test_perf();
        int stalls = 0, got = 0;
        pulse_start();
        for (int i = 0; i < 500; i++) begin
            weight_ready = 1'($urandom_range(0, 1));
            bias_ready   = 1'($urandom_range(0, 1));
            if (done === 1'b1) begin got = 1; break; end
            if (busy && ((weight_valid && !weight_ready) || (bias_valid && !bias_ready))) stalls++;
            @(posedge clk); #1;
        end
        weight_ready = 1'b1; bias_ready = 1'b1;
        n_checks++; if (got !== 1) begin n_fail++; $display("FAIL perf_done_timeout: done not seen"); end
        n_checks++; if (perf_stall_cycles !== 32'(stalls)) begin n_fail++; $display("FAIL perf_count: got %0d required %0d", perf_stall_cycles, stalls); end
        repeat (5) begin @(posedge clk); #1; end
        n_checks++; if (perf_stall_cycles !== 32'(stalls)) begin n_fail++; $display("FAIL perf_hold: got %0d required %0d", perf_stall_cycles, stalls); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; weight_ready = 1'b1; bias_ready = 1'b1;
        w_frame_hs = 0; b_frame_hs = 0; w_last = 0; b_last = 0;
        done_cnt = 0; w_iss = 0; w_hs_tot = 0; w_max_out = 0;

        // Scoreboard: expected tiles pushed at each accepted start, popped on every handshake
        fork
            forever begin : monitor
                int ea, bad, last;
                @(negedge clk);
                if (rst === 1'b1) begin
                    wq.delete(); bq.delete();
                    w_iss = 0; w_hs_tot = 0;
                end else begin
                    if (start === 1'b1 && busy === 1'b0 && done === 1'b0) begin
                        for (int s = 0; s < 8; s++) for (int k = 0; k < 4; k++) wq.push_back(k);
                        for (int s = 0; s < 8; s++) bq.push_back(0);
                        w_frame_hs = 0; b_frame_hs = 0; w_last = 0; b_last = 0; w_max_out = 0;
                    end
                    if (w_rd_en === 1'b1) w_iss++;
                    if (weight_valid === 1'b1 && weight_ready === 1'b1) begin
                        n_checks++;
                        if (wq.size() == 0) begin
                            n_fail++; $display("FAIL weight_extra: got tile at cycle %0d, required none", cyc);
                        end else begin
                            ea = wq.pop_front(); bad = -1;
                            for (int i = 0; i < WN; i++) if (bad < 0 && weight[i] !== wpat(ea, i)) bad = i;
                            if (bad >= 0) begin
                                n_fail++;
                                $display("FAIL weight_tile: tile %0d elem %0d got %h required %h (addr %0d)", w_frame_hs, bad, weight[bad], wpat(ea, bad), ea);
                            end
                        end
                        w_frame_hs++; w_hs_tot++; w_last = cyc;
                    end
                    if (bias_valid === 1'b1 && bias_ready === 1'b1) begin
                        n_checks++;
                        if (bq.size() == 0) begin
                            n_fail++; $display("FAIL bias_extra: got tile at cycle %0d, required none", cyc);
                        end else begin
                            ea = bq.pop_front(); bad = -1;
                            for (int i = 0; i < BN; i++) if (bad < 0 && bias[i] !== bpat(ea, i)) bad = i;
                            if (bad >= 0) begin
                                n_fail++;
                                $display("FAIL bias_tile: tile %0d elem %0d got %h required %h", b_frame_hs, bad, bias[bad], bpat(ea, bad));
                            end
                        end
                        b_frame_hs++; b_last = cyc;
                    end
                    if (w_iss - w_hs_tot > w_max_out) w_max_out = w_iss - w_hs_tot;
                    if (done === 1'b1) begin
                        done_cnt++;
                        last = (w_last > b_last) ? w_last : b_last;
                        n_checks++;
                        if (cyc !== last + 1 || w_frame_hs !== WTOT || b_frame_hs !== BTOT || wq.size() != 0 || bq.size() != 0) begin
                            n_fail++;
                            $display("FAIL done_frame: cycle %0d tiles %0d/%0d required cycle %0d tiles %0d/%0d", cyc, w_frame_hs, b_frame_hs, last + 1, WTOT, BTOT);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_basic();
        test_w_backpressure();
        test_b_stall();
        test_start_during_run();
        test_reset_mid_frame();
`ifdef CONV_PARAM_SCHED_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
